// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared encodings for the data-memory arbiter: arbitration
//                FSM states and read-owner tags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  // Arbitration FSM: open arbitration, or aux holding a locked burst
  typedef enum logic [0:0] {
    ARB      = 1'b0,
    AUX_HOLD = 1'b1
  } arb_state_t;

  // Which requester a returning read belongs to
  typedef enum logic [0:0] {
    OWNER_CPU = 1'b0,
    OWNER_AUX = 1'b1
  } owner_t;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arb_readtrack.sv
// ============================================================================
//  Module      : dmem_arb_readtrack
//  Description : Remembers who issued the read granted last cycle and raises
//                that requester's rvalid when the synchronous dmem returns.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_readtrack
  import dmem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   rd_fire,
  input  owner_t rd_owner,
  output logic   cpu_rvalid,
  output logic   aux_rvalid
);

  logic   r_pending;
  owner_t r_owner;

  // Capture the owner of a granted read; reset drops any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_owner   <= OWNER_CPU;
    end else begin
      r_pending <= rd_fire;
      if (rd_fire) begin
        r_owner <= rd_owner;
      end
    end
  end

  // Only one pending read exists, so at most one rvalid can be high
  always_comb begin
    cpu_rvalid = r_pending && (r_owner == OWNER_CPU);
    aux_rvalid = r_pending && (r_owner == OWNER_AUX);
  end

endmodule : dmem_arb_readtrack

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-master arbiter for the single-port data memory. The CPU
//                has fixed priority; a starvation counter and a capped aux
//                burst (lock) mode guarantee aux progress.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS         = 32,
  parameter int DMEMADDRBITS  = 13,
  parameter int DMEMWORDBITS  = 2,
  parameter int STARVE_LIMIT  = 4,
  parameter int AUX_BURST_MAX = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [DBITS-1:0]                 cpu_addr,
  input  logic [DBITS-1:0]                 cpu_wdata,
  output logic                             cpu_stall,
  output logic [DBITS-1:0]                 cpu_rdata,
  output logic                             cpu_rvalid,
  input  logic                             aux_req,
  input  logic                             aux_lock,
  input  logic                             aux_we,
  input  logic [DBITS-1:0]                 aux_addr,
  input  logic [DBITS-1:0]                 aux_wdata,
  output logic                             aux_gnt,
  output logic [DBITS-1:0]                 aux_rdata,
  output logic                             aux_rvalid,
  output logic                             mem_we,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
  output logic [DBITS-1:0]                 mem_wdata,
  input  logic [DBITS-1:0]                 mem_rdata
);

  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_BURST_W  = $clog2(AUX_BURST_MAX + 1);
  localparam int c_WIDX_W   = DMEMADDRBITS - DMEMWORDBITS;

  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [c_BURST_W-1:0]  c_BURST_MAX  = c_BURST_W'(AUX_BURST_MAX);
  localparam logic [c_BURST_W-1:0]  c_BURST_LAST = c_BURST_W'(AUX_BURST_MAX - 1);
  localparam logic [c_BURST_W-1:0]  c_BURST_ONE  = c_BURST_W'(1);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [c_STARVE_W-1:0]   r_starve_cnt;
  logic [c_BURST_W-1:0]    r_burst_cnt;

  logic                    w_cpu_gnt;
  logic                    w_aux_gnt;
  logic                    w_hold;
  logic                    w_starved;
  logic                    w_rd_fire;
  owner_t                  w_rd_owner;

  // Upper address bits alias and the byte offset is dropped by design
  logic                    w_unused_addr;
  assign w_unused_addr = ^{cpu_addr, aux_addr};

  assign w_starved = (r_starve_cnt == c_STARVE_MAX);

  // Grant decision and next state; a failed hold falls back to open
  // arbitration in the same cycle so no memory slot is wasted
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_aux_gnt    = 1'b0;
    w_hold       = 1'b0;
    w_next_state = ARB;
    if ((r_state == AUX_HOLD) && aux_req && aux_lock && (r_burst_cnt < c_BURST_MAX)) begin
      w_hold       = 1'b1;
      w_aux_gnt    = 1'b1;
      // Leave as the final burst grant is issued so the CPU owns the next slot
      w_next_state = (r_burst_cnt == c_BURST_LAST) ? ARB : AUX_HOLD;
    end else begin
      if (cpu_req && aux_req) begin
        if (w_starved) begin
          w_aux_gnt = 1'b1;
        end else begin
          w_cpu_gnt = 1'b1;
        end
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (aux_req) begin
        w_aux_gnt = 1'b1;
      end
      if (w_aux_gnt && aux_lock && (AUX_BURST_MAX > 1)) begin
        w_next_state = AUX_HOLD;
      end
    end
  end

  // FSM state, burst length and aux starvation tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB;
      r_burst_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state == ARB) begin
        r_burst_cnt <= '0;
      end else if (w_hold) begin
        r_burst_cnt <= r_burst_cnt + c_BURST_ONE;
      end else begin
        r_burst_cnt <= c_BURST_ONE;
      end

      if (!aux_req || w_aux_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_cpu_gnt && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Steer the winner onto the dmem port; idle bus is all zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = cpu_wdata;
    end else if (w_aux_gnt) begin
      mem_we    = aux_we;
      mem_addr  = aux_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = aux_wdata;
    end
  end

  // Requester-facing status and read data
  always_comb begin
    cpu_stall  = cpu_req && !w_cpu_gnt;
    aux_gnt    = w_aux_gnt;
    cpu_rdata  = mem_rdata;
    aux_rdata  = mem_rdata;
    w_rd_fire  = (w_cpu_gnt && !cpu_we) || (w_aux_gnt && !aux_we);
    w_rd_owner = w_aux_gnt ? OWNER_AUX : OWNER_CPU;
  end

  dmem_arb_readtrack u_readtrack (
    .clk        (clk),
    .reset      (reset),
    .rd_fire    (w_rd_fire),
    .rd_owner   (w_rd_owner),
    .cpu_rvalid (cpu_rvalid),
    .aux_rvalid (aux_rvalid)
  );

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a cycle model of
//                the arbitration rules and a behavioural dmem.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int DBITS         = 32;
  localparam int DMEMADDRBITS  = 13;
  localparam int DMEMWORDBITS  = 2;
  localparam int STARVE_LIMIT  = 4;
  localparam int AUX_BURST_MAX = 8;
  localparam int WIDX_W        = DMEMADDRBITS - DMEMWORDBITS;
  localparam int DEPTH         = 1 << WIDX_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, aux_req, aux_lock, aux_we;
  logic [DBITS-1:0]  cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic              cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid, mem_we;
  logic [DBITS-1:0]  cpu_rdata, aux_rdata, mem_wdata, mem_rdata;
  logic [WIDX_W-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .DBITS(DBITS), .DMEMADDRBITS(DMEMADDRBITS), .DMEMWORDBITS(DMEMWORDBITS),
    .STARVE_LIMIT(STARVE_LIMIT), .AUX_BURST_MAX(AUX_BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_lock(aux_lock), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous single-port dmem
  logic [DBITS-1:0] dmem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) dmem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               rst_pulses = 0;
  int               rst_seen   = 0;
  always @(posedge reset) rst_pulses++;

  logic [DBITS-1:0] shadow [DEPTH];
  int               m_lost;      // consecutive cycles aux requested and lost
  int               m_burst;     // grants so far in the current locked burst
  bit               m_in_burst;
  bit               m_pend;
  bit               m_pend_aux;
  logic [DBITS-1:0] m_pend_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    m_lost = 0; m_burst = 0; m_in_burst = 0; m_pend = 0; m_pend_aux = 0; m_pend_data = '0;
  end

  always @(negedge clk) begin : compare
    int               win;      // 0 none, 1 cpu, 2 aux
    bit               hold;
    logic [DBITS-1:0] waddr;
    logic [WIDX_W-1:0] widx;
    bit               wwe;
    logic [DBITS-1:0] wdat;

    if (rst_seen != rst_pulses || reset) begin
      rst_seen   = rst_pulses;
      m_lost     = 0;
      m_burst    = 0;
      m_in_burst = 0;
      m_pend     = 0;
    end

    if (reset) begin
      check("reset cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      check("reset aux_rvalid", {31'b0, aux_rvalid}, 32'd0);
    end else begin
      hold = m_in_burst && aux_req && aux_lock && (m_burst < AUX_BURST_MAX);
      if (hold)                   win = 2;
      else if (cpu_req && aux_req) win = (m_lost == STARVE_LIMIT) ? 2 : 1;
      else if (cpu_req)           win = 1;
      else if (aux_req)           win = 2;
      else                        win = 0;

      waddr = (win == 1) ? cpu_addr  : (win == 2) ? aux_addr  : '0;
      wdat  = (win == 1) ? cpu_wdata : (win == 2) ? aux_wdata : '0;
      wwe   = (win == 1) ? cpu_we    : (win == 2) ? aux_we    : 1'b0;
      widx  = (win == 0) ? '0 : WIDX_W'(waddr / 4);

      check("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && (win != 1)});
      check("aux_gnt",   {31'b0, aux_gnt},   {31'b0, win == 2});
      check("mem_we",    {31'b0, mem_we},    {31'b0, wwe});
      check("mem_addr",  32'(mem_addr),      32'(widx));
      check("mem_wdata", mem_wdata,          wdat);
      check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_pend && !m_pend_aux});
      check("aux_rvalid", {31'b0, aux_rvalid}, {31'b0, m_pend && m_pend_aux});
      if (m_pend && !m_pend_aux) check("cpu_rdata", cpu_rdata, m_pend_data);
      if (m_pend && m_pend_aux)  check("aux_rdata", aux_rdata, m_pend_data);

      // advance model to the next cycle
      m_pend      = (win != 0) && !wwe;
      m_pend_aux  = (win == 2);
      m_pend_data = shadow[widx];
      if ((win != 0) && wwe) shadow[widx] = wdat;

      if (aux_req && win == 1) m_lost = (m_lost < STARVE_LIMIT) ? m_lost + 1 : m_lost;
      else                     m_lost = 0;

      if (win == 2) begin
        if (hold)          m_burst = m_burst + 1;
        else if (aux_lock) m_burst = 1;
        else               m_burst = 0;
        m_in_burst = (hold || aux_lock) && (m_burst < AUX_BURST_MAX);
      end else begin
        m_in_burst = 0;
        m_burst    = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_lock = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("rst stall",  {31'b0, cpu_stall},  32'd0);
    check("rst gnt",    {31'b0, aux_gnt},    32'd0);
    check("rst mem_we", {31'b0, mem_we},     32'd0);
    next_cycle();
    reset = 1'b0;

    // 1: CPU store then load, no aux
    next_cycle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0; cpu_wdata = 32'h1234abcd;
    @(negedge clk);
    check("t1 store stall", {31'b0, cpu_stall}, 32'd0);
    check("t1 store we",    {31'b0, mem_we},    32'd1);
    next_cycle();
    cpu_we = 0; cpu_wdata = '0;
    @(negedge clk);
    check("t1 load stall", {31'b0, cpu_stall}, 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1 rvalid", {31'b0, cpu_rvalid}, 32'd1);
    check("t1 rdata",  cpu_rdata,           32'h1234abcd);

    // 2: both request, no lock: aux wins every fifth cycle
    next_cycle();
    cpu_req = 1; cpu_addr = 32'h4;
    aux_req = 1; aux_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t2 aux_gnt[%0d]", i),   {31'b0, aux_gnt},   {31'b0, (i % 5) == 4});
      check($sformatf("t2 cpu_stall[%0d]", i), {31'b0, cpu_stall}, {31'b0, (i % 5) == 4});
      next_cycle();
    end
    idle();
    @(negedge clk);

    // 3: aux write then read back
    next_cycle();
    aux_req = 1; aux_we = 1; aux_addr = 32'h40; aux_wdata = 32'hdeadbeef;
    @(negedge clk);
    check("t3 wr gnt", {31'b0, aux_gnt}, 32'd1);
    next_cycle();
    aux_we = 0; aux_wdata = '0;
    @(negedge clk);
    check("t3 rd gnt", {31'b0, aux_gnt}, 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3 aux_rvalid", {31'b0, aux_rvalid}, 32'd1);
    check("t3 aux_rdata",  aux_rdata,           32'hdeadbeef);
    check("t3 cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);

    // 4: locked burst against a requesting CPU
    next_cycle();
    cpu_req = 1; cpu_addr = 32'h0;
    aux_req = 1; aux_lock = 1; aux_addr = 32'h40;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("t4 aux_gnt[%0d]", i),   {31'b0, aux_gnt},   {31'b0, (i >= 4) && (i <= 11)});
      check($sformatf("t4 cpu_stall[%0d]", i), {31'b0, cpu_stall}, {31'b0, (i >= 4) && (i <= 11)});
      next_cycle();
    end
    idle();
    @(negedge clk);

    // 5: reset pulsed while an aux read is in flight
    next_cycle();
    aux_req = 1; aux_addr = 32'h40;
    @(negedge clk);
    check("t5 gnt", {31'b0, aux_gnt}, 32'd1);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    idle();
    @(negedge clk);
    check("t5 aux_rvalid", {31'b0, aux_rvalid}, 32'd0);
    next_cycle();
    cpu_req = 1; cpu_addr = 32'h4;
    aux_req = 1; aux_addr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5 post aux_gnt[%0d]", i), {31'b0, aux_gnt}, {31'b0, i == 4});
      next_cycle();
    end
    idle();

    // 6: upper address bits alias
    next_cycle();
    cpu_req = 1; cpu_addr = 32'hF0001004;
    @(negedge clk);
    check("t6 mem_addr", 32'(mem_addr), 32'h401);
    next_cycle();
    idle();
    @(negedge clk);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory behind the memory stage between two requesters: the CPU memory stage (primary) and an auxiliary master (secondary), such as a program loader or DMA engine.
- CPU has fixed priority. A starvation counter and a bounded aux lock (burst) mode keep the aux side from waiting forever.
- Read data comes back one cycle after grant, tagged to its owner; the CPU is stalled in any cycle it loses arbitration.
- Sits between the memory stage's dmem-range access path and the dmem instance. I/O-mapped addresses (KEY/SW/HEX/LEDR) never reach this block.

Parameters:
DBITS, 32, data and address width
DMEMADDRBITS, 13, byte-address bits used for dmem
DMEMWORDBITS, 2, byte-offset bits dropped to form the word index
STARVE_LIMIT, 4, consecutive lost cycles after which aux wins over the CPU
AUX_BURST_MAX, 8, maximum consecutive locked aux grant cycles

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU dmem access request
cpu_we  in  1  1=store, 0=load
cpu_addr  in  DBITS  CPU byte address
cpu_wdata  in  DBITS  CPU store data
cpu_stall  out  1  CPU lost arbitration this cycle; hold request
cpu_rdata  out  DBITS  load data
cpu_rvalid  out  1  cpu_rdata valid (cycle after granted load)
aux_req  in  1  aux access request
aux_lock  in  1  request to keep grant on following cycles (burst)
aux_we  in  1  1=write, 0=read
aux_addr  in  DBITS  aux byte address
aux_wdata  in  DBITS  aux write data
aux_gnt  out  1  aux access accepted this cycle
aux_rdata  out  DBITS  aux read data
aux_rvalid  out  1  aux_rdata valid
mem_we  out  1  dmem write enable
mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  dmem word index = addr[DMEMADDRBITS-1:DMEMWORDBITS]
mem_wdata  out  DBITS  dmem write data
mem_rdata  in  DBITS  dmem read data, synchronous, valid 1 cycle after address

Behaviour:
- Reset (async, active-high):
  - State ARB, starve_cnt=0, burst_cnt=0, pending-read flags cleared.
  - cpu_rvalid=aux_rvalid=0. cpu_stall=aux_gnt=mem_we=0 while no requests are present.
- Grant is combinational in the current cycle. The mem_* bus carries the winner's signals; with no winner, mem_we=0 and mem_addr/mem_wdata=0.
- State ARB:
  - Only one requester → it wins.
  - Both request → CPU wins unless starve_cnt==STARVE_LIMIT, in which case aux wins.
  - Aux wins with aux_lock=1 → go to AUX_HOLD, burst_cnt=1.
- State AUX_HOLD:
  - Aux wins unconditionally while aux_req && aux_lock && burst_cnt<AUX_BURST_MAX; burst_cnt increments on each grant.
  - Exit to ARB when aux_req=0, aux_lock=0, or burst_cnt==AUX_BURST_MAX.
  - On a forced exit (cap reached), the next cycle is in ARB with starve_cnt=0, so a requesting CPU wins it.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when aux_req=1 and the CPU wins.
  - Clears when aux wins or aux_req=0.
- Outputs:
  - cpu_stall = cpu_req && !cpu_granted.
  - aux_gnt = aux granted.
  - A requester must hold req/we/addr/wdata stable until granted.
- Read return:
  - A granted read sets owner/pending registers.
  - On the next cycle the owner's rvalid=1; both rdata outputs are driven from mem_rdata and qualified by rvalid.
  - Writes never produce rvalid. At most one rvalid is high per cycle.
- Back-to-back granted reads from either side give rvalid on consecutive cycles.
- Reset asserted while a read is pending drops that read; no rvalid follows.
- aux_lock is ignored if aux_req=0. Address bits above DMEMADDRBITS are ignored (aliasing).

Decomposition:
- Shared package/header (alongside Decoder.vh): FSM state encodings ARB/AUX_HOLD and owner encodings OWNER_CPU/OWNER_AUX.
- One natural sub-module: dmem_arb_readtrack, which holds the registered owner/pending flags and produces the rvalid pair.
- Grant logic and the FSM stay in the top module.

Test Plan:
1. Reset then CPU store 0x1234abcd to addr 0, then load from addr 0, no aux → cpu_stall=0 throughout; cpu_rvalid=1 one cycle after the load, cpu_rdata=0x1234abcd.
2. Both request continuously, aux_lock=0 → CPU wins 4 cycles with cpu_stall=0; cycle 5 aux_gnt=1, cpu_stall=1; pattern repeats every 5 cycles.
3. Aux writes 0xdeadbeef to addr 0x40, aux reads it back → aux_gnt=1 each cycle; aux_rvalid=1 next cycle with aux_rdata=0xdeadbeef; cpu_rvalid stays 0.
4. aux_lock=1 burst while CPU requests, AUX_BURST_MAX=8 → after the starve grant, aux holds for 8 grants total; next cycle CPU granted, cpu_stall=0.
5. Aux read granted, then reset pulsed mid-cycle before the return edge → aux_rvalid=0 and all counters 0 after reset.
6. cpu_addr=0xF0001004 → mem_addr=0x401 (upper bits aliased).
